// File: rtl/nibble_serial_addsub_pkg.sv
// rtl/nibble_serial_addsub_pkg.sv - shared types and constants for the nibble-serial adder/subtractor
package addsub_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_addsub_if.sv
// rtl/nibble_serial_addsub_if.sv - request/result handshake bundle for the nibble-serial adder/subtractor
interface nibble_serial_addsub_if
  import addsub_pkg::*;
#(
  parameter int NIBBLES = 4
);

  logic                        in_valid;
  logic                        in_ready;
  logic [NIBBLE_W*NIBBLES-1:0] a;
  logic [NIBBLE_W*NIBBLES-1:0] b;
  logic                        ctrl;
  logic                        out_valid;
  logic                        out_ready;
  logic [NIBBLE_W*NIBBLES-1:0] s;
  logic                        cout;
  logic                        ovf;
  logic                        zero;

  // requester side: issues operands and consumes the result
  modport master (
    output in_valid, a, b, ctrl, out_ready,
    input  in_ready, out_valid, s, cout, ovf, zero
  );

  // arithmetic unit side
  modport slave (
    input  in_valid, a, b, ctrl, out_ready,
    output in_ready, out_valid, s, cout, ovf, zero
  );

endinterface

// File: rtl/nibble_serial_addsub_core.sv
// rtl/nibble_serial_addsub_core.sv - 4-bit add/subtract slice exposing carry into and out of bit 3
module addsub4_core
  import addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a4,
  input  logic [NIBBLE_W-1:0] b4,
  input  logic                ctrl,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum4,
  output logic                cout4,
  output logic                c3
);

  logic [NIBBLE_W-1:0] bx;
  logic [NIBBLE_W-1:0] low;
  logic [1:0]          high;

  // low three bits and msb are added separately so the carry into bit 3 is visible for overflow
  always_comb begin
    bx    = (ctrl == OP_SUB) ? ~b4 : b4;
    low   = {1'b0, a4[2:0]} + {1'b0, bx[2:0]} + {3'b000, cin};
    c3    = low[3];
    high  = {1'b0, a4[3]} + {1'b0, bx[3]} + {1'b0, c3};
    sum4  = {high[0], low[2:0]};
    cout4 = high[1];
  end

endmodule

// File: rtl/nibble_serial_addsub.sv
// rtl/nibble_serial_addsub.sv - nibble-serial add/subtract unit with valid/ready handshakes
module nibble_serial_addsub
  import addsub_pkg::*;
#(
  parameter int NIBBLES = 4
)(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                        ctrl,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] s,
  output logic                        cout,
  output logic                        ovf,
  output logic                        zero
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t             state, state_next;
  logic [W-1:0]       a_r, b_r;
  logic               ctrl_r;
  logic               carry;
  logic [IDX_W-1:0]   idx;
  logic               last;
  logic [NIBBLE_W-1:0] a_nib, b_nib, sum4;
  logic               c_out, c_in3;
  logic [W-1:0]       s_next;

  addsub4_core u_core (
    .a4    (a_nib),
    .b4    (b_nib),
    .ctrl  (ctrl_r),
    .cin   (carry),
    .sum4  (sum4),
    .cout4 (c_out),
    .c3    (c_in3)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // next-state and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // select the operand nibbles for the current index and merge the new result nibble into s
  always_comb begin
    last   = (idx == IDX_W'(NIBBLES - 1));
    a_nib  = '0;
    b_nib  = '0;
    s_next = s;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IDX_W'(i)) begin
        a_nib = a_r[i*NIBBLE_W +: NIBBLE_W];
        b_nib = b_r[i*NIBBLE_W +: NIBBLE_W];
        s_next[i*NIBBLE_W +: NIBBLE_W] = sum4;
      end
    end
  end

  // operand capture, per-nibble accumulation and final flag registration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      ctrl_r <= OP_ADD;
      carry  <= 1'b0;
      idx    <= '0;
      s      <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r    <= a;
            b_r    <= b;
            ctrl_r <= ctrl;
            carry  <= (ctrl == OP_ADD) ? 1'b0 : 1'b1;
            idx    <= '0;
          end
        end
        RUN: begin
          s     <= s_next;
          carry <= c_out;
          idx   <= idx + IDX_W'(1);
          if (last) begin
            cout <= c_out;
            ovf  <= c_in3 ^ c_out;
            zero <= (s_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// tb/tb_nibble_serial_addsub.sv - directed vector bench for nibble_serial_addsub
module tb_nibble_serial_addsub;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ctrl;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  nibble_serial_addsub_if #(.NIBBLES(4)) bus ();

  nibble_serial_addsub #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .a         (bus.a),
    .b         (bus.b),
    .ctrl      (bus.ctrl),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .s         (bus.s),
    .cout      (bus.cout),
    .ovf       (bus.ovf),
    .zero      (bus.zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // drive one request at a negedge; returns cycles from accept edge to out_valid (-1 on timeout)
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic ctrl, output int lat);
    @(negedge clk);
    chk("in_ready_before_issue", {31'd0, bus.in_ready}, 32'd1);
    bus.a = a; bus.b = b; bus.ctrl = ctrl; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = 16'hDEAD; bus.b = 16'hBEEF; bus.ctrl = ~ctrl;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL out_valid_timeout: got none expected within 20 cycles");
    end
  endtask

  task automatic retire();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("out_valid_after_retire", {31'd0, bus.out_valid}, 32'd0);
  endtask

  vec_t vecs[10];
  int   lat;

  initial begin
    n_cmp = 0; n_fail = 0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.ctrl = 1'b0; bus.out_ready = 1'b0;

    vecs[0] = '{16'h0001, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h0002, 16'h0004, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};

    // reset state
    rst_n = 1'b0;
    #12;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_s", {16'd0, bus.s}, 32'd0);
    chk("rst_flags", {29'd0, bus.cout, bus.ovf, bus.zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven vectors
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].ctrl, lat);
      if (lat >= 0) begin
        chk($sformatf("v%0d_latency", i), lat, 32'd4);
        chk($sformatf("v%0d_s", i), {16'd0, bus.s}, {16'd0, vecs[i].s});
        chk($sformatf("v%0d_cout", i), {31'd0, bus.cout}, {31'd0, vecs[i].cout});
        chk($sformatf("v%0d_ovf", i), {31'd0, bus.ovf}, {31'd0, vecs[i].ovf});
        chk($sformatf("v%0d_zero", i), {31'd0, bus.zero}, {31'd0, vecs[i].zero});
        chk($sformatf("v%0d_in_ready_done", i), {31'd0, bus.in_ready}, 32'd0);
      end
      retire();
    end

    // hold in DONE with out_ready low; a new request must be ignored
    issue(16'h0005, 16'h0003, 1'b0, lat);
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = (c == 1 || c == 2);
      bus.a = 16'hAAAA; bus.b = 16'h1111; bus.ctrl = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("hold_s", {16'd0, bus.s}, 32'h0008);
      chk("hold_flags", {29'd0, bus.cout, bus.ovf, bus.zero}, 32'd0);
      chk("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid = 1'b0;
    retire();
    chk("hold_in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
    chk("hold_s_kept_idle", {16'd0, bus.s}, 32'h0008);

    // asynchronous reset after two RUN cycles
    @(negedge clk);
    bus.a = 16'h00B0; bus.b = 16'h0060; bus.ctrl = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("midrun_s_partial", {16'd0, bus.s}, 32'h0010);
    rst_n = 1'b0;
    #1;
    chk("async_rst_s", {16'd0, bus.s}, 32'd0);
    chk("async_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("async_rst_flags", {29'd0, bus.cout, bus.ovf, bus.zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_rst_no_output", {31'd0, bus.out_valid}, 32'd0);
    end
    issue(16'h0003, 16'h0004, 1'b0, lat);
    if (lat >= 0) begin
      chk("post_rst_latency", lat, 32'd4);
      chk("post_rst_s", {16'd0, bus.s}, 32'h0007);
    end
    retire();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
